data_mem_ctrl: RTL and testbench

//   Clocked, parametrised data memory for the CPU load/store path. Little-endian byte array.

---
 rtl/dmem_defs_pkg.sv | 9 +
 rtl/dmem_load_align.sv | 24 ++
 rtl/data_mem_ctrl.sv | 120 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dmem_defs_pkg.sv
// dmem_defs_pkg: shared encodings for the data memory controller
//   SIZE_BYTE/SIZE_HALF/SIZE_WORD : access size codes (2'b11 is reserved)
//   state_t                       : controller FSM states IDLE/WAIT/RESP
package dmem_defs_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed byte/half lane of a 32-bit word and extends it
//   i_word   : aligned word containing the access
//   i_a      : low two address bits (lane select)
//   i_size   : access size; word and reserved codes pass the word through
//   i_signed : 1 sign-extends, 0 zero-extends
//   o_data   : extended load result
module dmem_load_align
  import dmem_defs_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_a,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);
  logic [31:0] w_shift;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_shift = i_word >> {i_a, 3'b000};
  assign w_b     = w_shift[7:0];
  assign w_h     = i_a[1] ? i_word[31:16] : i_word[15:0];
  assign o_data  = i_size == SIZE_BYTE ? {{24{i_signed & w_b[7]}}, w_b} :
                   i_size == SIZE_HALF ? {{16{i_signed & w_h[15]}}, w_h} : i_word;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: little-endian byte-array data memory with req/ready handshake and wait states
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_req / o_ready  : request handshake, accept = i_req && o_ready
//   i_rw, i_size, i_signed, i_addr, i_wdata : access fields, captured on accept
//   o_valid          : one-cycle response pulse, WAIT_CYCLES+1 cycles after accept
//   o_rdata, o_err   : load result and rejection flag, held until the next o_valid
//   Define DMEM_ERR_EN to reject misaligned, reserved-size and out-of-range accesses;
//   otherwise addresses wrap, are forced aligned, and size 2'b11 acts as a word.
module data_mem_ctrl
  import dmem_defs_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_rw,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_valid,
  output logic              o_err
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_ready, r_valid, r_err;
  logic [31:0]       r_rdata;
  logic              r_rw, r_signed;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [7:0]        r_mem [DEPTH_BYTES];
  logic              w_idle, w_accept, w_go_resp, w_we, w_err;
  logic              w_rw, w_signed;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, w_word, w_load;
  logic [AW-1:0]     w_idx, w_a, w_base;
  assign w_idle    = r_state == ST_IDLE;
  assign w_accept  = i_req && r_ready;
  assign w_go_resp = (r_state == ST_WAIT && r_cnt == LAST) || (WAIT_CYCLES == 0 && w_accept);
  // With no wait states the access happens on the accept edge, so use the live inputs
  assign w_rw     = w_idle ? i_rw     : r_rw;
  assign w_size   = w_idle ? i_size   : r_size;
  assign w_signed = w_idle ? i_signed : r_signed;
  assign w_addr   = w_idle ? i_addr   : r_addr;
  assign w_wdata  = w_idle ? i_wdata  : r_wdata;
  assign w_idx    = w_addr[AW-1:0];
`ifdef DMEM_ERR_EN
  assign w_a   = w_idx;
  assign w_err = w_size == 2'b11 || (w_size == SIZE_HALF && w_idx[0]) ||
                 (w_size == SIZE_WORD && w_idx[1:0] != 2'b00) || (w_addr >> AW) != '0;
`else
  assign w_a   = w_size == SIZE_BYTE ? w_idx :
                 w_size == SIZE_HALF ? {w_idx[AW-1:1], 1'b0} : {w_idx[AW-1:2], 2'b00};
  assign w_err = 1'b0;
`endif
  assign w_we   = w_go_resp && w_rw && !w_err;
  assign w_base = {w_a[AW-1:2], 2'b00};
  assign w_word = {r_mem[w_base + AW'(3)], r_mem[w_base + AW'(2)],
                   r_mem[w_base + AW'(1)], r_mem[w_base]};
  dmem_load_align u_align (
    .i_word   (w_word),
    .i_a      (w_a[1:0]),
    .i_size   (w_size),
    .i_signed (w_signed),
    .o_data   (w_load)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_rw     <= 1'b0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_go_resp ? ST_RESP : w_accept ? ST_WAIT : r_state == ST_RESP ? ST_IDLE : r_state;
      r_cnt   <= (r_state == ST_WAIT && !w_go_resp) ? r_cnt + 4'd1 : 4'd0;
      r_ready <= r_state == ST_RESP || (w_idle && !w_accept);
      r_valid <= w_go_resp;
      if (w_accept) begin
        r_rw     <= i_rw;
        r_size   <= i_size;
        r_signed <= i_signed;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
      end
      if (w_go_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_rw || w_err) ? 32'd0 : w_load;
      end
    end
  // Array is not reset; writes land on the edge that enters RESP
  always_ff @(posedge i_clk)
    if (w_we) begin
      r_mem[w_a] <= w_wdata[7:0];
      if (w_size != SIZE_BYTE) r_mem[w_a + AW'(1)] <= w_wdata[15:8];
      if (w_size[1]) begin
        r_mem[w_a + AW'(2)] <= w_wdata[23:16];
        r_mem[w_a + AW'(3)] <= w_wdata[31:24];
      end
    end
  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_rdata = r_rdata;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances)
module tb_data_mem_ctrl;
  typedef struct {
    bit          ld;
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req1 = 1'b0, req0 = 1'b0;
  logic        rw = 1'b0, sgn = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready1, valid1, err1, ready0, valid0, err0;
  logic [31:0] rdata1, rdata0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb1[$];
  exp_t        sb0[$];
  exp_t        x1, x0;

  data_mem_ctrl #(.ADDR_W(32), .DEPTH_BYTES(256), .WAIT_CYCLES(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .o_ready(ready1), .i_rw(rw), .i_size(size),
    .i_signed(sgn), .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata1), .o_valid(valid1), .o_err(err1)
  );
  data_mem_ctrl #(.ADDR_W(32), .DEPTH_BYTES(256), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .o_ready(ready0), .i_rw(rw), .i_size(size),
    .i_signed(sgn), .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata0), .o_valid(valid0), .o_err(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && valid1) begin
      chk("w1_ready_during_valid", {31'd0, ready1}, 32'd0);
      if (sb1.size() == 0) chk("w1_unexpected_valid", 32'd1, 32'd0);
      else begin
        x1 = sb1.pop_front();
        chk("w1_latency", cyc, x1.cyc);
        chk("w1_err", {31'd0, err1}, {31'd0, x1.err});
        if (x1.ld) chk("w1_rdata", rdata1, x1.data);
      end
    end

  always @(negedge clk)
    if (rst_n && valid0) begin
      chk("w0_ready_during_valid", {31'd0, ready0}, 32'd0);
      if (sb0.size() == 0) chk("w0_unexpected_valid", 32'd1, 32'd0);
      else begin
        x0 = sb0.pop_front();
        chk("w0_latency", cyc, x0.cyc);
        chk("w0_err", {31'd0, err0}, {31'd0, x0.err});
        if (x0.ld) chk("w0_rdata", rdata0, x0.data);
      end
    end

  // Issue one access and wait for its response; fields are scrambled right after accept
  task automatic issue(input bit sel, input bit rw_i, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit e_err,
                       input logic [31:0] e_data);
    int n;
    @(negedge clk);
    rw = rw_i; size = sz; sgn = sg; addr = a; wdata = wd;
    if (sel) req0 = 1'b1; else req1 = 1'b1;
    n = 0;
    while (!(sel ? ready0 : ready1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd1, 32'd0);
    else begin
      if (sel) sb0.push_back('{!rw_i, e_err, e_data, cyc + 1});
      else sb1.push_back('{!rw_i, e_err, e_data, cyc + 2});
      @(posedge clk);
      #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    addr = $urandom; wdata = $urandom; sgn = ~sg; size = ~sz;
    n = 0;
    while ((sel ? sb0.size() : sb1.size()) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("response_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready1}, 32'd0);
    chk("reset_valid", {31'd0, valid1}, 32'd0);
    chk("reset_err", {31'd0, err1}, 32'd0);
    chk("reset_rdata", rdata1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'd0, ready1}, 32'd1);

    issue(0, 1, 2'b10, 0, 32'h10, 32'h8899AABC, 0, 32'h0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h8899AABC);
    issue(0, 0, 2'b00, 1, 32'h11, 32'h0, 0, 32'hFFFFFFAA);
    issue(0, 0, 2'b00, 0, 32'h11, 32'h0, 0, 32'h000000AA);
    issue(0, 0, 2'b01, 1, 32'h12, 32'h0, 0, 32'hFFFF8899);
    issue(0, 0, 2'b01, 0, 32'h12, 32'h0, 0, 32'h00008899);
    issue(0, 0, 2'b00, 1, 32'h10, 32'h0, 0, 32'hFFFFFFBC);
    issue(0, 1, 2'b01, 0, 32'h12, 32'hFFFF1234, 0, 32'h0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234AABC);
    issue(0, 1, 2'b00, 0, 32'h10, 32'hAABBCC77, 0, 32'h0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234AA77);
`ifdef DMEM_ERR_EN
    issue(0, 0, 2'b10, 0, 32'h11, 32'h0, 1, 32'h0);
    issue(0, 1, 2'b01, 0, 32'h13, 32'h5555, 1, 32'h0);
    issue(0, 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'h0);
    issue(0, 1, 2'b10, 0, 32'h110, 32'h66666666, 1, 32'h0);
    issue(0, 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0);
    issue(0, 1, 2'b11, 0, 32'h10, 32'h77777777, 1, 32'h0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234AA77);
`else
    issue(0, 0, 2'b10, 0, 32'h11, 32'h0, 0, 32'h1234AA77);
    issue(0, 0, 2'b01, 0, 32'h13, 32'h0, 0, 32'h00001234);
    issue(0, 0, 2'b10, 0, 32'h110, 32'h0, 0, 32'h1234AA77);
    issue(0, 0, 2'b11, 0, 32'h10, 32'h0, 0, 32'h1234AA77);
`endif

    // Req held for several cycles: one accept per IDLE visit
    @(negedge clk);
    rw = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h10; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (ready1) sb1.push_back('{1'b1, 1'b0, 32'h1234AA77, cyc + 2});
      @(negedge clk);
    end
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_req_drained", sb1.size(), 32'd0);

    // No wait states: Valid on the cycle right after accept
    issue(1, 1, 2'b10, 0, 32'h40, 32'h01020304, 0, 32'h0);
    issue(1, 0, 2'b00, 1, 32'h43, 32'h0, 0, 32'h00000001);
    issue(1, 0, 2'b01, 0, 32'h40, 32'h0, 0, 32'h00000304);
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h01020304);

    // Reset while in WAIT aborts a store
    issue(0, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 32'h0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234AA77);
    @(negedge clk);
    rw = 1'b1; size = 2'b10; sgn = 1'b0; addr = 32'h20; wdata = 32'hDEADBEEF; req1 = 1'b1;
    chk("abort_ready_before", {31'd0, ready1}, 32'd1);
    @(posedge clk);
    #1 req1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, valid1}, 32'd0);
    chk("abort_err", {31'd0, err1}, 32'd0);
    chk("abort_rdata", rdata1, 32'd0);
    chk("abort_ready", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", {31'd0, ready1}, 32'd1);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
